baud_gen_frac: RTL
==================

// Module: baud_gen_frac
// PURPOSE
//   Parametrised baud/oversample tick generator for UART Tx/Rx.
//   - Sample period = div_int + div_frac/2^FRAC_W clocks; fractional divisor reaches
//     standard baud rates from arbitrary system clocks.
//   - baud_tick is derived from every OVS-th sample tick, so Tx and Rx timing stay phase-locked.
//   - resync re-phases the generator on an Rx start-bit edge.
//   - mid_tick marks the bit centre.
// PARAMETERS
//   DIV_W   16  width of integer divisor
//   FRAC_W  4   width of fractional divisor (units of 1/2^FRAC_W clock)
//   OVS     16  sample ticks per bit; even, >=4
//   OVS_W   $clog2(OVS)  width of sample_idx (derived, do not override)
// PORTS
//   clk          in   1       system clock, rising edge
//   reset        in   1       asynchronous, active-high
//   enable       in   1       1 = run; 0 = freeze all counters
//   resync       in   1       synchronous re-phase pulse
//   div_int      in   DIV_W   integer clocks per sample tick; 0 is treated as 1
//   div_frac     in   FRAC_W  fractional clocks per sample tick
//   sample_tick  out  1       1-cycle pulse at OVS x baud rate
//   baud_tick    out  1       1-cycle pulse once per bit, coincident with a sample_tick
//   mid_tick     out  1       1-cycle pulse at bit centre, coincident with a sample_tick
//   sample_idx   out  OVS_W   sample ticks since last bit boundary, 0..OVS-1
// BEHAVIOUR
//   - Reset: all counters and accumulators 0; all outputs 0 (sample_idx=0).
//   - All outputs are registered.
//   - Period counter cnt[DIV_W-1:0]:
//     - Counts enabled cycles.
//     - Wraps when cnt >= max(div_int,1)-1+ext, where ext is the stored fractional carry (0/1).
//     - The ">=" compare makes a live divisor decrease take effect at once, without a stuck counter.
//   - On wrap:
//     - cnt<=0; sample_tick<=1.
//     - {carry,acc} <= acc + div_frac (FRAC_W+1 bit add); ext<=carry.
//     - sample_idx <= (sample_idx==OVS-1) ? 0 : sample_idx+1.
//     - baud_tick<=1 iff sample_idx wraps to 0.
//     - mid_tick<=1 iff sample_idx becomes OVS/2.
//   - On a non-wrap cycle, all ticks are 0.
//   - Ticks are never held high for more than 1 cycle.
//   - First sample_tick after reset release (enable=1, frac=0): high in the cycle after the
//     div_int-th rising edge, then every div_int cycles.
//   - enable=0:
//     - cnt, acc, ext and sample_idx hold.
//     - All ticks are 0 that cycle.
//     - Resuming continues the same phase.
//   - resync=1 (priority over enable):
//     - cnt, acc, ext and sample_idx cleared to 0; ticks 0 that cycle.
//     - First sample_tick follows a full period later.
//     - mid_tick falls OVS/2 sample periods after resync (start-bit centre).
//   - Divisor change mid-period: new value is used in the next compare; acc is not cleared.
//   - div_int=1 with frac=0: sample_tick is high every cycle.
//   - div_int=0 behaves exactly like div_int=1.
//   - Reset asserted mid-operation: outputs go to 0 asynchronously; same sequence restarts from zero.
// CONFIGURATION
//   BAUD_FRAC_EN defined:
//     - Fractional accumulator and ext are implemented as above.
//   BAUD_FRAC_EN undefined:
//     - div_frac port is present but ignored; acc and ext are absent (ext==0).
//     - Period is exactly max(div_int,1).
// TESTING
//   1. div_int=4, frac=0, OVS=16, enable=1 -> sample_tick every 4 clk; baud_tick every 64 clk,
//      coincident with sample_idx 15->0; mid_tick when idx=8.
//   2. BAUD_FRAC_EN, div_int=4, div_frac=8 (0.5) -> sample periods 4,4,5,4,5,...;
//      first baud_tick after 71 clk, then every 72 clk.
//   3. div_int=0 and div_int=1 -> sample_tick constant 1 after the first edge;
//      baud_tick every 16 clk.
//   4. enable low for 10 cycles at cnt=2 -> no ticks during the gap;
//      next sample_tick occurs 2 enabled cycles after release.
//   5. resync pulse at idx=5 -> idx=0; mid_tick exactly 8*div_int+1 clk later, baud_tick at 16*div_int+1;
//      resync together with enable=0 still clears.
//   6. div_int changed 100->10 while cnt=50 -> wrap on the next cycle; then 10-cycle periods;
//      reset asserted mid-bit -> all outputs 0 immediately.

Source files
------------

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-divisor oversample/baud/mid-bit tick generator for UART Tx/Rx.
// Define BAUD_FRAC_EN to enable the fractional accumulator; otherwise div_frac is ignored.
module baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OVS    = 16,
  parameter int OVS_W  = $clog2(OVS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              resync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              sample_tick,
  output logic              baud_tick,
  output logic              mid_tick,
  output logic [OVS_W-1:0]  sample_idx
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_eff;
  logic [DIV_W:0]   limit;
  logic             ext;
  logic             wrap;
  logic [OVS_W-1:0] idx_nxt;
  assign div_eff = (div_int == '0) ? DIV_W'(1) : div_int;
  // ">=" rather than "==" so a live divisor decrease wraps immediately instead of running to overflow
  assign limit   = {1'b0, div_eff} - (DIV_W+1)'(1) + (DIV_W+1)'(ext);
  assign wrap    = enable && !resync && ({1'b0, cnt} >= limit);
  assign idx_nxt = (sample_idx == OVS_W'(OVS-1)) ? '0 : sample_idx + OVS_W'(1);
`ifdef BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (resync) begin
      acc <= '0;
      ext <= 1'b0;
    end else if (wrap) begin
      {ext, acc} <= {1'b0, acc} + {1'b0, div_frac};
    end
  end
`else
  assign ext = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      sample_idx  <= '0;
      sample_tick <= 1'b0;
      baud_tick   <= 1'b0;
      mid_tick    <= 1'b0;
    end else begin
      sample_tick <= wrap;
      baud_tick   <= wrap && (idx_nxt == '0);
      mid_tick    <= wrap && (idx_nxt == OVS_W'(OVS/2));
      if (resync) begin
        cnt        <= '0;
        sample_idx <= '0;
      end else if (enable) begin
        cnt <= wrap ? '0 : cnt + DIV_W'(1);
        if (wrap) sample_idx <= idx_nxt;
      end
    end
  end
endmodule
